// File: rtl/ppu_scanline_buf_pkg.sv
// Shared definitions for the ping-pong scanline buffer: widths, write-side
// states and the black palette index shown before the first line is swapped in.
package ppu_scanline_buf_pkg;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned PIX_W  = 6;
  localparam int unsigned ADDR_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_LAST  = 8'hFF;
  localparam logic [PIX_W-1:0]  SBUF_BLANK = 6'h0F;

  typedef enum logic {
    SBUF_FILL = 1'b0,
    SBUF_FULL = 1'b1
  } sbuf_wr_states_t;

endpackage

// File: rtl/ppu_scanline_buf_if.sv
// PPU write stream and VGA read/swap signals of the scanline buffer.
// master = PPU/VGA side driving the buffer, slave = the buffer itself.
interface ppu_scanline_buf_if;
  import ppu_scanline_buf_pkg::*;

  logic              wr_valid;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_sol;
  logic              wr_ready;
  logic [ADDR_W-1:0] vga_buf_idx;
  logic [PIX_W-1:0]  vga_buf_out;
  logic              vga_swap;

  modport master (
    output wr_valid, wr_data, wr_sol, vga_buf_idx, vga_swap,
    input  wr_ready, vga_buf_out
  );

  modport slave (
    input  wr_valid, wr_data, wr_sol, vga_buf_idx, vga_swap,
    output wr_ready, vga_buf_out
  );

endinterface

// File: rtl/ppu_scanline_buf_ram.sv
// One scanline bank: 256 x PIX_W, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module sbuf_ram
  import ppu_scanline_buf_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [LINE_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ppu_scanline_buf.sv
// Ping-pong scanline buffer: PPU fills the back bank, VGA reads the front bank,
// banks swap on a VGA line-pair boundary only when a full line is waiting.
module ppu_scanline_buf
  import ppu_scanline_buf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ppu_clk_en,
  input  logic                vga_clk_en,
  ppu_scanline_buf_if.slave   sbuf,
  output logic                overflow,
  output logic [7:0]          underrun_cnt
);

  sbuf_wr_states_t   state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, ptr_nxt;
  logic              rd_bank, bank_nxt;
  logic              shown_valid, shown_nxt;
  logic              ovf_nxt;
  logic [7:0]        und_nxt;
  logic              wr_ready;

  logic              wr_hit, wr_accept, swap_ev;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  rd0, rd1;

  assign wr_hit    = ppu_clk_en & sbuf.wr_valid;
  assign wr_accept = wr_hit & (state == SBUF_FILL);
  assign wr_addr   = sbuf.wr_sol ? '0 : wr_ptr;
  assign swap_ev   = vga_clk_en & sbuf.vga_swap;

  // Swap decision looks only at the registered state, so a final pixel landing
  // together with vga_swap still counts as an underrun.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = wr_ptr;
    bank_nxt  = rd_bank;
    shown_nxt = shown_valid;
    ovf_nxt   = overflow;
    und_nxt   = underrun_cnt;
    case (state)
      SBUF_FILL: begin
        if (wr_accept) begin
          if (wr_addr == ADDR_LAST) begin
            state_nxt = SBUF_FULL;
            ptr_nxt   = '0;
          end else begin
            ptr_nxt = wr_addr + 8'd1;
          end
        end
        if (swap_ev && underrun_cnt != '1) und_nxt = underrun_cnt + 8'd1;
      end
      SBUF_FULL: begin
        if (wr_hit) ovf_nxt = 1'b1;
        if (swap_ev) begin
          bank_nxt  = ~rd_bank;
          state_nxt = SBUF_FILL;
          shown_nxt = 1'b1;
        end
      end
      default: state_nxt = SBUF_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SBUF_FILL;
      wr_ptr       <= '0;
      rd_bank      <= 1'b0;
      shown_valid  <= 1'b0;
      overflow     <= 1'b0;
      underrun_cnt <= '0;
      wr_ready     <= 1'b1;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= ptr_nxt;
      rd_bank      <= bank_nxt;
      shown_valid  <= shown_nxt;
      overflow     <= ovf_nxt;
      underrun_cnt <= und_nxt;
      wr_ready     <= (state_nxt == SBUF_FILL);
    end
  end

  // Back bank is ~rd_bank.
  sbuf_ram u_bank0 (
    .clk   (clk),
    .we    (wr_accept & rd_bank),
    .waddr (wr_addr),
    .wdata (sbuf.wr_data),
    .raddr (sbuf.vga_buf_idx),
    .rdata (rd0)
  );

  sbuf_ram u_bank1 (
    .clk   (clk),
    .we    (wr_accept & ~rd_bank),
    .waddr (wr_addr),
    .wdata (sbuf.wr_data),
    .raddr (sbuf.vga_buf_idx),
    .rdata (rd1)
  );

  assign sbuf.wr_ready    = wr_ready;
  assign sbuf.vga_buf_out = shown_valid ? (rd_bank ? rd1 : rd0) : SBUF_BLANK;

endmodule
